seven_seg_scan_driver: RTL

//  Parametrised multiplexed seven-segment scanner for N hex digits, driven from the FPGA wrapper.

---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/seven_seg_hex_decoder.sv | 15 +
 rtl/seven_seg_scan_driver.sv | 115 +++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex digit to active-high segment pattern, with blanking.
// Blanked digits produce SEG_BLANK regardless of the nibble.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with guard gap and frame-shadowed inputs.
// Optional PWM brightness gate when SEVEN_SEG_BRIGHTNESS_EN is defined.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS     = 4,
  parameter  int REFRESH_CYCLES = 200_000,
  parameter  int GUARD_CYCLES   = 256,
  parameter  int ACTIVE_LOW     = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int CNT_W =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]              slot_cnt;
  logic [NUM_DIGITS-1:0][3:0]    sh_val;
  logic [NUM_DIGITS-1:0]         sh_en;
  logic [NUM_DIGITS-1:0]         sh_dp;
  logic                          slot_end;
  logic                          frame_end;
  logic                          gate;
  logic                          guard;
  logic [NUM_DIGITS-1:0]         an_on;
  seg_t                          dec_seg;

  assign slot_end  = (slot_cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign frame_end = slot_end
                   && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign guard     = (slot_cnt < CNT_W'(GUARD_CYCLES));

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign gate = (pwm_cnt <= brightness);
`else
  assign gate = 1'b1;
`endif

  always_comb begin
    an_on = '0;
    if (!guard && sh_en[digit_idx] && gate) begin
      an_on[digit_idx] = 1'b1;
    end
  end

  seven_seg_hex_decoder u_dec (
    .nibble (sh_val[digit_idx]),
    .blank  (!sh_en[digit_idx]),
    .seg    (dec_seg)
  );

  // Inputs are captured only on the frame wrap so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      sh_val     <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        slot_cnt <= '0;
        if (frame_end) begin
          digit_idx <= '0;
          sh_val    <= value;
          sh_en     <= digit_en;
          sh_dp     <= dp_in;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= dec_seg ^ {7{POL}};
      dp  <= sh_dp[digit_idx] ^ POL;
      an  <= an_on ^ {NUM_DIGITS{POL}};
    end
  end

endmodule
